// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode slice: widths, instruction field positions, FSM encoding.
// Latency: n/a (types, constants and a pure helper only).
// Backpressure: n/a.
package isa_pkg;

    localparam int DATA_W = 16;
    localparam int PC_W   = 32;
    localparam int NREG   = 8;
    localparam int REG_AW = 3;
    localparam int OPC_W  = 5;
    localparam int SHM_W  = 5;

    // Instruction word field positions
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 11;
    localparam int RS_HI  = 10;
    localparam int RS_LO  = 8;
    localparam int RD_HI  = 7;
    localparam int RD_LO  = 5;
    localparam int SHM_HI = 4;
    localparam int SHM_LO = 0;

    typedef enum logic {
        ST_DECODE   = 1'b0,
        ST_WAIT_IMM = 1'b1
    } state_t;

    // Decoded instruction fields, as they travel from IF/ID into ID/EX
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [OPC_W-1:0]  opcode;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rd;
        logic [SHM_W-1:0]  shmnt;
    } instr_t;

    // ID/EX pipeline register contents
    typedef struct packed {
        logic              valid;
        instr_t            ins;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rd_data;
        logic [DATA_W-1:0] imm;
        logic              has_imm;
    } idex_t;

    // Rebuild the raw 16-bit word from the fields fetch already split out;
    // used to recover the immediate carried by the second word.
    function automatic logic [DATA_W-1:0] pack_word(
        input logic [OPC_W-1:0]  opcode,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd,
        input logic [SHM_W-1:0]  shmnt
    );
        logic [DATA_W-1:0] w;
        w                = '0;
        w[OPC_HI:OPC_LO] = opcode;
        w[RS_HI:RS_LO]   = rs;
        w[RD_HI:RD_LO]   = rd;
        w[SHM_HI:SHM_LO] = shmnt;
        return w;
    endfunction

endpackage

// File: rtl/register_file.sv
// 8x16 register file, one write port and two combinational read ports with write bypass.
// Latency: reads 0 cycles (same-cycle write data forwarded); writes land on the rising edge.
// Backpressure: none; writes are always accepted.
// Ports: clk/rst_n; we/waddr/wdata write port; raddr_a/rdata_a, raddr_b/rdata_b read ports.
module register_file
    import isa_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // A write in flight this cycle is visible to readers in the same cycle.
    assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
    assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// ID stage: register read, two-word immediate merge, ID/EX register with stall/flush.
// Latency: 1 cycle for single-word instructions, 1 cycle after the immediate word otherwise.
// Backpressure: stall holds ID/EX, FSM and pending latch (upstream holds IF/ID); flush beats stall.
// Ports: if_* IF/ID fields in; wb_* write-back port; id_* ID/EX register out; id_busy = waiting on immediate.
module decode_stage
    import isa_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [PC_W-1:0]   if_pc,
    input  logic              if_is_imm,
    input  logic [OPC_W-1:0]  if_opcode,
    input  logic [REG_AW-1:0] if_rs,
    input  logic [REG_AW-1:0] if_rd,
    input  logic [SHM_W-1:0]  if_shmnt,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_valid,
    output logic [PC_W-1:0]   id_pc,
    output logic [OPC_W-1:0]  id_opcode,
    output logic [REG_AW-1:0] id_rs,
    output logic [REG_AW-1:0] id_rd,
    output logic [SHM_W-1:0]  id_shmnt,
    output logic [DATA_W-1:0] id_rs_data,
    output logic [DATA_W-1:0] id_rd_data,
    output logic [DATA_W-1:0] id_imm,
    output logic              id_has_imm,
    output logic              id_busy
);

    state_t            state;
    instr_t            pend;
    idex_t             idex;
    instr_t            cur;
    logic [REG_AW-1:0] rd_addr_a;
    logic [REG_AW-1:0] rd_addr_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic [DATA_W-1:0] imm_word;

    assign cur = '{pc: if_pc, opcode: if_opcode, rs: if_rs, rd: if_rd, shmnt: if_shmnt};

    // While waiting for the immediate, the IF/ID register/address bits belong to the
    // immediate, so the register file must be addressed from the pending latch.
    assign rd_addr_a = (state == ST_WAIT_IMM) ? pend.rs : if_rs;
    assign rd_addr_b = (state == ST_WAIT_IMM) ? pend.rd : if_rd;
    assign imm_word  = pack_word(if_opcode, if_rs, if_rd, if_shmnt);

    register_file u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rd_addr_a),
        .raddr_b (rd_addr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_DECODE;
            pend  <= '0;
            idex  <= '0;
        end else if (flush) begin
            // Immediate is cleared with has_imm so id_imm stays 0 whenever has_imm is 0.
            idex.valid   <= 1'b0;
            idex.has_imm <= 1'b0;
            idex.imm     <= '0;
            state        <= ST_DECODE;
            pend         <= '0;
        end else if (!stall) begin
            unique case (state)
                ST_DECODE: begin
                    if (!if_valid) begin
                        idex.valid <= 1'b0;
                    end else if (!if_is_imm) begin
                        idex <= '{valid: 1'b1, ins: cur, rs_data: rdata_a, rd_data: rdata_b,
                                  imm: '0, has_imm: 1'b0};
                    end else begin
                        pend       <= cur;
                        idex.valid <= 1'b0;
                        state      <= ST_WAIT_IMM;
                    end
                end
                ST_WAIT_IMM: begin
                    // if_is_imm on the immediate word carries no meaning and is ignored.
                    if (!if_valid) begin
                        idex.valid <= 1'b0;
                    end else begin
                        idex <= '{valid: 1'b1, ins: pend, rs_data: rdata_a, rd_data: rdata_b,
                                  imm: imm_word, has_imm: 1'b1};
                        pend  <= '0;
                        state <= ST_DECODE;
                    end
                end
            endcase
        end
    end

    assign id_valid   = idex.valid;
    assign id_pc      = idex.ins.pc;
    assign id_opcode  = idex.ins.opcode;
    assign id_rs      = idex.ins.rs;
    assign id_rd      = idex.ins.rd;
    assign id_shmnt   = idex.ins.shmnt;
    assign id_rs_data = idex.rs_data;
    assign id_rd_data = idex.rd_data;
    assign id_imm     = idex.imm;
    assign id_has_imm = idex.has_imm;
    assign id_busy    = (state == ST_WAIT_IMM);

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic against a transaction model.
// Latency: n/a.
// Backpressure: exercises stall and flush from the bench side.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_is_imm;
    logic [4:0]  if_opcode;
    logic [2:0]  if_rs;
    logic [2:0]  if_rd;
    logic [4:0]  if_shmnt;
    logic        stall;
    logic        flush;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_opcode;
    logic [2:0]  id_rs;
    logic [2:0]  id_rd;
    logic [4:0]  id_shmnt;
    logic [15:0] id_rs_data;
    logic [15:0] id_rd_data;
    logic [15:0] id_imm;
    logic        id_has_imm;
    logic        id_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_is_imm  (if_is_imm),
        .if_opcode  (if_opcode),
        .if_rs      (if_rs),
        .if_rd      (if_rd),
        .if_shmnt   (if_shmnt),
        .stall      (stall),
        .flush      (flush),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_opcode  (id_opcode),
        .id_rs      (id_rs),
        .id_rd      (id_rd),
        .id_shmnt   (id_shmnt),
        .id_rs_data (id_rs_data),
        .id_rd_data (id_rd_data),
        .id_imm     (id_imm),
        .id_has_imm (id_has_imm),
        .id_busy    (id_busy)
    );

    // ---------------- reference model: instructions waiting for their immediate ----------------
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  op;
        logic [2:0]  rs;
        logic [2:0]  rd;
        logic [4:0]  sh;
    } rec_t;

    rec_t        pend_q[$];
    logic [15:0] m_regs [8];
    logic        e_valid;
    logic [31:0] e_pc;
    logic [4:0]  e_op;
    logic [2:0]  e_rs;
    logic [2:0]  e_rd;
    logic [4:0]  e_sh;
    logic [15:0] e_rsd;
    logic [15:0] e_rdd;
    logic [15:0] e_imm;
    logic        e_has;

    function automatic logic [15:0] mread(input logic [2:0] a);
        return (wb_we && wb_addr == a) ? wb_data : m_regs[a];
    endfunction

    task automatic model_reset();
        pend_q.delete();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        e_valid = 0; e_pc = 0; e_op = 0; e_rs = 0; e_rd = 0; e_sh = 0;
        e_rsd = 0; e_rdd = 0; e_imm = 0; e_has = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven, then clock the DUT.
    task automatic tick();
        rec_t r;
        if (flush) begin
            pend_q.delete();
            e_valid = 0;
            e_has   = 0;
        end else if (!stall) begin
            if (!if_valid) begin
                e_valid = 0;
            end else if (pend_q.size() > 0) begin
                r = pend_q.pop_front();
                e_valid = 1; e_pc = r.pc; e_op = r.op; e_rs = r.rs; e_rd = r.rd; e_sh = r.sh;
                e_rsd = mread(r.rs); e_rdd = mread(r.rd);
                e_imm = {if_opcode, if_rs, if_rd, if_shmnt};
                e_has = 1;
            end else if (if_is_imm) begin
                r.pc = if_pc; r.op = if_opcode; r.rs = if_rs; r.rd = if_rd; r.sh = if_shmnt;
                pend_q.push_back(r);
                e_valid = 0;
            end else begin
                e_valid = 1; e_pc = if_pc; e_op = if_opcode; e_rs = if_rs; e_rd = if_rd; e_sh = if_shmnt;
                e_rsd = mread(if_rs); e_rdd = mread(if_rd);
                e_imm = 0; e_has = 0;
            end
        end
        if (wb_we) m_regs[wb_addr] = wb_data;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic imm, input logic [31:0] pc, input logic [4:0] op,
                         input logic [2:0] rs, input logic [2:0] rd, input logic [4:0] sh);
        if_valid = v; if_is_imm = imm; if_pc = pc; if_opcode = op;
        if_rs = rs; if_rd = rd; if_shmnt = sh;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 0; stall = 0; flush = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({id_valid, id_pc, id_opcode, id_rs, id_rd, id_shmnt, id_rs_data, id_rd_data, id_imm, id_has_imm, id_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%0b pc=%0h busy=%0b required all zero", id_valid, id_pc, id_busy);
        end
        rst_n = 1;
        drive(1, 1, 32'h10, 5'h10, 3'd1, 3'd2, 5'd0);
        tick();
        checks++;
        if (id_busy !== 1'b1 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_pre_wait got busy=%0b valid=%0b required busy=1 valid=0", id_busy, id_valid);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({id_valid, id_pc, id_opcode, id_rs, id_rd, id_shmnt, id_rs_data, id_rd_data, id_imm, id_has_imm, id_busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait got valid=%0b busy=%0b pc=%0h required all zero", id_valid, id_busy, id_pc);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        drive(1, 0, 32'h11, 5'h02, 3'd3, 3'd4, 5'd6);
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_opcode !== 5'h02 || id_pc !== 32'h11 || id_has_imm !== 1'b0 ||
            id_busy !== 1'b0 || id_rs_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_then_issue got valid=%0b op=%0h pc=%0h has=%0b busy=%0b rsd=%0h required 1 02 11 0 0 0",
                     id_valid, id_opcode, id_pc, id_has_imm, id_busy, id_rs_data);
        end
    endtask

    task automatic test_single();
        drive(0, 0, 0, 0, 0, 0, 0);
        wb_we = 1; wb_addr = 3'd2; wb_data = 16'h1234;
        tick();
        wb_addr = 3'd5; wb_data = 16'h00FF;
        tick();
        wb_we = 0;
        drive(1, 0, 32'h21, 5'h03, 3'd2, 3'd5, 5'd4);
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_rs_data !== 16'h1234 || id_rd_data !== 16'h00FF ||
            id_pc !== 32'h21 || id_has_imm !== 1'b0 || id_shmnt !== 5'd4 || id_imm !== 16'h0) begin
            errors++;
            $display("FAIL single_issue got valid=%0b rsd=%0h rdd=%0h pc=%0h has=%0b sh=%0d imm=%0h required 1 1234 00ff 21 0 4 0",
                     id_valid, id_rs_data, id_rd_data, id_pc, id_has_imm, id_shmnt, id_imm);
        end
    endtask

    task automatic test_imm_merge();
        drive(1, 1, 32'h40, 5'h10, 3'd1, 3'd3, 5'd0);
        tick();
        checks++;
        if (id_valid !== 1'b0 || id_busy !== 1'b1) begin
            errors++;
            $display("FAIL imm_first got valid=%0b busy=%0b required 0 1", id_valid, id_busy);
        end
        drive(0, 0, 32'h0, 5'h0, 3'd0, 3'd0, 5'd0);
        tick();
        checks++;
        if (id_valid !== 1'b0 || id_busy !== 1'b1) begin
            errors++;
            $display("FAIL imm_gap got valid=%0b busy=%0b required 0 1", id_valid, id_busy);
        end
        drive(1, 0, 32'h41, 5'h1F, 3'd7, 3'd7, 5'h1F);
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_imm !== 16'hFFFF || id_rs !== 3'd1 || id_rd !== 3'd3 ||
            id_pc !== 32'h40 || id_has_imm !== 1'b1 || id_busy !== 1'b0 || id_opcode !== 5'h10 ||
            id_rs_data !== 16'h0 || id_rd_data !== 16'h0) begin
            errors++;
            $display("FAIL imm_issue got valid=%0b imm=%0h rs=%0d rd=%0d pc=%0h has=%0b busy=%0b op=%0h required 1 ffff 1 3 40 1 0 10",
                     id_valid, id_imm, id_rs, id_rd, id_pc, id_has_imm, id_busy, id_opcode);
        end
    endtask

    task automatic test_bypass();
        wb_we = 1; wb_addr = 3'd2; wb_data = 16'hBEEF;
        drive(1, 0, 32'h60, 5'h04, 3'd2, 3'd5, 5'd0);
        tick();
        checks++;
        if (id_rs_data !== 16'hBEEF || id_rd_data !== 16'h00FF) begin
            errors++;
            $display("FAIL bypass_same_cycle got rsd=%0h rdd=%0h required beef 00ff", id_rs_data, id_rd_data);
        end
        wb_we = 0;
        drive(1, 0, 32'h61, 5'h04, 3'd2, 3'd2, 5'd0);
        tick();
        checks++;
        if (id_rs_data !== 16'hBEEF || id_rd_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL bypass_after got rsd=%0h rdd=%0h required beef beef", id_rs_data, id_rd_data);
        end
        drive(1, 1, 32'h62, 5'h08, 3'd4, 3'd2, 5'd0);
        tick();
        wb_we = 1; wb_addr = 3'd4; wb_data = 16'hCAFE;
        drive(1, 0, 32'h63, 5'h00, 3'd0, 3'd0, 5'd1);
        tick();
        wb_we = 0;
        checks++;
        if (id_rs_data !== 16'hCAFE || id_rd_data !== 16'hBEEF || id_imm !== 16'h0001 || id_pc !== 32'h62) begin
            errors++;
            $display("FAIL bypass_imm_issue got rsd=%0h rdd=%0h imm=%0h pc=%0h required cafe beef 0001 62",
                     id_rs_data, id_rd_data, id_imm, id_pc);
        end
    endtask

    task automatic test_stall_flush();
        drive(1, 0, 32'h70, 5'h05, 3'd2, 3'd4, 5'd3);
        tick();
        stall = 1;
        wb_we = 1; wb_addr = 3'd2; wb_data = 16'h1111;
        drive(1, 0, 32'h71, 5'h06, 3'd1, 3'd1, 5'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h70 || id_opcode !== 5'h05 || id_rs_data !== 16'hBEEF ||
                id_rd_data !== 16'hCAFE) begin
                errors++;
                $display("FAIL stall_hold[%0d] got valid=%0b pc=%0h op=%0h rsd=%0h rdd=%0h required 1 70 05 beef cafe",
                         i, id_valid, id_pc, id_opcode, id_rs_data, id_rd_data);
            end
        end
        wb_we = 0;
        flush = 1;
        tick();
        checks++;
        if (id_valid !== 1'b0 || id_busy !== 1'b0 || id_has_imm !== 1'b0) begin
            errors++;
            $display("FAIL stall_flush got valid=%0b busy=%0b has=%0b required 0 0 0", id_valid, id_busy, id_has_imm);
        end
        stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_flush_wait();
        drive(1, 1, 32'h80, 5'h09, 3'd3, 3'd3, 5'd0);
        tick();
        flush = 1;
        drive(1, 0, 32'h81, 5'h01, 3'd1, 3'd1, 5'd1);
        tick();
        checks++;
        if (id_busy !== 1'b0 || id_valid !== 1'b0 || id_has_imm !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait got busy=%0b valid=%0b has=%0b required 0 0 0", id_busy, id_valid, id_has_imm);
        end
        flush = 0;
        drive(1, 0, 32'h82, 5'h0A, 3'd1, 3'd2, 5'd5);
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_has_imm !== 1'b0 || id_opcode !== 5'h0A || id_pc !== 32'h82 ||
            id_busy !== 1'b0 || id_shmnt !== 5'd5) begin
            errors++;
            $display("FAIL flush_fresh got valid=%0b has=%0b op=%0h pc=%0h busy=%0b sh=%0d required 1 0 0a 82 0 5",
                     id_valid, id_has_imm, id_opcode, id_pc, id_busy, id_shmnt);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            stall = ($urandom_range(0, 99) < 15);
            flush = ($urandom_range(0, 99) < 5);
            wb_we = ($urandom_range(0, 1) == 1);
            wb_addr = 3'($urandom_range(0, 7));
            wb_data = 16'($urandom);
            drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30, $urandom,
                  5'($urandom), 3'($urandom), 3'($urandom), 5'($urandom));
            tick();
            checks++;
            if (id_valid !== e_valid || id_busy !== (pend_q.size() != 0)) begin
                errors++;
                $display("FAIL rand_ctrl[%0d] got valid=%0b busy=%0b required %0b %0b",
                         n, id_valid, id_busy, e_valid, pend_q.size() != 0);
            end
            if (e_valid) begin
                checks++;
                if ({id_pc, id_opcode, id_rs, id_rd, id_shmnt, id_rs_data, id_rd_data, id_imm, id_has_imm} !==
                    {e_pc, e_op, e_rs, e_rd, e_sh, e_rsd, e_rdd, e_imm, e_has}) begin
                    errors++;
                    $display("FAIL rand_fields[%0d] got pc=%0h op=%0h rs=%0d rd=%0d sh=%0d rsd=%0h rdd=%0h imm=%0h has=%0b required %0h %0h %0d %0d %0d %0h %0h %0h %0b",
                             n, id_pc, id_opcode, id_rs, id_rd, id_shmnt, id_rs_data, id_rd_data, id_imm, id_has_imm,
                             e_pc, e_op, e_rs, e_rd, e_sh, e_rsd, e_rdd, e_imm, e_has);
                end
            end
        end
        stall = 0; flush = 0; wb_we = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_imm_merge();
        test_bypass();
        test_stall_flush();
        test_flush_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage, directly downstream of the fetch stage; consumes the IF/ID fields (PC+1, isImmediate, SHMNT, Rd, Rs, opCode).
- Owns the 8-entry register file, read with write-back bypass.
- Merges two-word immediate instructions into one issue.
- Drives the ID/EX pipeline register, with stall and flush control.

Parameters:
- DATA_W, 16, register and instruction word width.
- PC_W, 32, PC width.
- NREG, 8, register count; the address width is 3.

Ports:
- clk  in  1  stage clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_valid  in  1  IF/ID holds a valid word.
- if_pc  in  PC_W  next-instruction address from fetch.
- if_is_imm  in  1  instruction is followed by a 16-bit immediate word.
- if_opcode  in  5  bits [15:11] of the fetched word.
- if_rs  in  3  bits [10:8].
- if_rd  in  3  bits [7:5].
- if_shmnt  in  5  bits [4:0].
- stall  in  1  hold ID/EX and the FSM.
- flush  in  1  kill decode contents; has priority over stall.
- wb_we  in  1  register-file write enable from write-back.
- wb_addr  in  3  write register.
- wb_data  in  DATA_W  write data.
- id_valid  out  1  ID/EX holds a valid instruction.
- id_pc  out  PC_W  PC+1 of the issued instruction (first word).
- id_opcode  out  5  opcode.
- id_rs  out  3  source register.
- id_rd  out  3  destination register.
- id_shmnt  out  5  shift amount.
- id_rs_data  out  DATA_W  value of R[rs].
- id_rd_data  out  DATA_W  value of R[rd].
- id_imm  out  DATA_W  immediate; 0 when id_has_imm=0.
- id_has_imm  out  1  issued instruction carried an immediate.
- id_busy  out  1  FSM is in WAIT_IMM.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs go to 0.
  - All registers R0..R7 go to 0.
  - FSM goes to DECODE.
  - The pending-instruction latch is cleared.
- Register file:
  - Write on the rising edge when wb_we=1; all 8 registers are writable.
  - Reads are combinational with bypass: if wb_we=1 and wb_addr equals the read address, wb_data is read in the same cycle.
  - Writes occur regardless of stall or flush.
- FSM, state DECODE:
  - if_valid=0: issue a bubble (id_valid<=0).
  - if_valid=1, if_is_imm=0: issue in 1 cycle. id_valid<=1, fields copied, rs/rd data read this cycle, id_has_imm<=0, id_imm<=0.
  - if_valid=1, if_is_imm=1: latch pc/opcode/rs/rd/shmnt into the pending latch, id_valid<=0, go to WAIT_IMM.
- FSM, state WAIT_IMM:
  - if_valid=0: remain in WAIT_IMM, id_valid<=0.
  - if_valid=1: the word is the immediate, {if_opcode,if_rs,if_rd,if_shmnt} (16 bits). Issue the pending instruction: id_valid<=1, id_has_imm<=1, id_imm<=word. Register data is read in this issue cycle using the latched rs/rd, with bypass. id_pc is the latched PC. Return to DECODE.
  - if_is_imm on the immediate word is ignored.
- Latency: 1 cycle for single-word instructions; 1 cycle after the second word for immediate instructions.
- stall=1 (flush=0):
  - ID/EX outputs, FSM state and the pending latch hold.
  - IF inputs are ignored; upstream must hold them.
- flush=1:
  - id_valid<=0, id_has_imm<=0, FSM goes to DECODE, the pending latch is discarded.
  - Other ID/EX fields may hold.
  - Flush and stall in the same cycle: flush wins.
- id_busy = (state==WAIT_IMM), combinational from state.
- Register data is sampled only at issue. Later writes do not update an already-issued ID/EX entry.

Decomposition:
- Shared package (isa_pkg):
  - Opcode field constants and field bit positions (15:11, 10:8, 7:5, 4:0).
  - DATA_W and register-count constants.
  - FSM state encoding DECODE=0, WAIT_IMM=1.
- One sub-module, register_file: 8x16, one write port, two combinational read ports with bypass, async active-low reset. decode_stage holds the FSM, the pending latch and the ID/EX register.

Test Plan:
- Reset mid-WAIT_IMM: drive an imm instruction, then assert rst_n=0 → all outputs 0, id_busy=0, and a following non-imm word issues normally.
- Single-word issue: write R2=0x1234 and R5=0x00FF, then send opcode=0x03, rs=2, rd=5, shmnt=4, pc=0x21 → next cycle id_valid=1, id_rs_data=0x1234, id_rd_data=0x00FF, id_pc=0x21, id_has_imm=0.
- Immediate merge: send opcode=0x10, rs=1, rd=3, is_imm=1, then one if_valid=0 cycle, then word fields 0x1F,7,7,0x1F → id_valid=0 for two cycles, then id_valid=1, id_imm=0xFFFF, id_rs=1, id_rd=3, id_pc=first word's PC.
- Bypass: in the issue cycle wb_we=1, wb_addr=2, wb_data=0xBEEF with rs=2 → id_rs_data=0xBEEF. The next issue also reads 0xBEEF.
- Stall then flush: issue A, hold stall=1 for 3 cycles while presenting B → ID/EX keeps A. Then assert stall=1 and flush=1 together → id_valid=0, state DECODE.
- Flush in WAIT_IMM: send an imm first word, then flush=1 → id_busy=0, id_valid=0. The next word decodes as a fresh instruction.
